game_flow_controller: RTL and testbench



---
 rtl/game_flow_pkg.sv | 50 +++++
 rtl/flow_timer.sv | 40 ++++
 rtl/game_flow_controller.sv | 135 +++++++++++++
 tb/tb_game_flow_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_pkg.sv
// rtl/game_flow_pkg.sv - shared types, defaults and screen ids for the pinball game-flow controller
package game_flow_pkg;

   typedef enum logic [2:0] {
      S_WELCOME   = 3'd0,
      S_PLAY      = 3'd1,
      S_PAUSE     = 3'd2,
      S_LEVEL_UP  = 3'd3,
      S_GAME_OVER = 3'd4,
      S_WIN       = 3'd5
   } game_state_t;

   localparam int DEF_LIFE_W        = 4;
   localparam int DEF_NUM_LEVELS    = 4;
   localparam int DEF_LEVEL_W       = 3;
   localparam int DEF_BANNER_CYCLES = 50000000;
   localparam int DEF_END_TIMEOUT   = 500000000;

   // Screen ids selected by the drawing mux.
   localparam logic [2:0] SCREEN_WELCOME   = 3'd0;
   localparam logic [2:0] SCREEN_GAME      = 3'd1;
   localparam logic [2:0] SCREEN_PAUSE     = 3'd2;
   localparam logic [2:0] SCREEN_BANNER    = 3'd3;
   localparam logic [2:0] SCREEN_GAME_OVER = 3'd4;
   localparam logic [2:0] SCREEN_WIN       = 3'd5;

   function automatic logic [2:0] screen_id(input game_state_t s);
      logic [2:0] id;
      id = SCREEN_WELCOME;
      case (s)
         S_PLAY:      id = SCREEN_GAME;
         S_PAUSE:     id = SCREEN_PAUSE;
         S_LEVEL_UP:  id = SCREEN_BANNER;
         S_GAME_OVER: id = SCREEN_GAME_OVER;
         S_WIN:       id = SCREEN_WIN;
         default:     id = SCREEN_WELCOME;
      endcase
      return id;
   endfunction

   // One spare bit above the largest terminal count keeps the compare unambiguous.
   function automatic int timer_width(input int banner, input int tout);
      int m;
      m = 2;
      if (banner > m) m = banner;
      if (tout > m) m = tout;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/flow_timer.sv
// rtl/flow_timer.sv - loadable/clearable up-counter with terminal-count compare
module flow_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] tc_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == tc_val_i);

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - pinball game-flow FSM: welcome, play, pause, level-up, game-over, win
module game_flow_controller
   import game_flow_pkg::*;
#(
   parameter int LIFE_W        = DEF_LIFE_W,
   parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
   parameter int LEVEL_W       = DEF_LEVEL_W,
   parameter int BANNER_CYCLES = DEF_BANNER_CYCLES,
   parameter int END_TIMEOUT   = DEF_END_TIMEOUT
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              keyStartPressed,
   input  logic              keyPausePressed,
   input  logic              keyRestartPressed,
   input  logic [LIFE_W-1:0] life,
   input  logic              levelCleared,
   output logic              start,
   output logic              game_end,
   output logic              freeze,
   output logic              paused,
   output logic              levelBannerOn,
   output logic              gameWon,
   output logic              screenWelcomeOperational,
   output logic [LEVEL_W-1:0] level
);

   localparam int CNT_W = timer_width(BANNER_CYCLES, END_TIMEOUT);
   localparam logic [CNT_W-1:0]   BANNER_TC  = CNT_W'(BANNER_CYCLES - 1);
   localparam logic [CNT_W-1:0]   END_TC     = (END_TIMEOUT == 0) ? '0 : CNT_W'(END_TIMEOUT - 1);
   localparam logic               END_EN     = (END_TIMEOUT != 0);
   localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

   game_state_t       state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;

   logic              timer_clr;
   logic              timer_en;
   logic [CNT_W-1:0]  timer_tc_val;
   logic [CNT_W-1:0]  timer_count;
   logic              timer_tc;

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         S_WELCOME: begin
            if (keyStartPressed) begin
               state_d = S_PLAY;
               level_d = '0;
            end
         end
         S_PLAY: begin
            if (life == '0) begin
               state_d = S_GAME_OVER;
            end else if (levelCleared) begin
               if (level_q == LAST_LEVEL) begin
                  state_d = S_WIN;
               end else begin
                  state_d = S_LEVEL_UP;
                  level_d = level_q + LEVEL_W'(1);
               end
            end else if (keyPausePressed) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (keyRestartPressed) begin
               state_d = S_WELCOME;
            end else if (keyPausePressed) begin
               state_d = S_PLAY;
            end
         end
         S_LEVEL_UP: begin
            if (timer_tc) begin
               state_d = S_PLAY;
            end
         end
         S_GAME_OVER, S_WIN: begin
            if (keyRestartPressed) begin
               state_d = S_WELCOME;
            end else if (END_EN && timer_tc) begin
               state_d = S_WELCOME;
            end
         end
         default: begin
            state_d = S_WELCOME;
         end
      endcase
   end

   // Timer runs only on timed screens and restarts from zero on every state change.
   always_comb begin
      timer_en     = (state_q == S_LEVEL_UP) || (state_q == S_GAME_OVER) || (state_q == S_WIN);
      timer_clr    = (state_d != state_q) || !timer_en;
      timer_tc_val = (state_q == S_LEVEL_UP) ? BANNER_TC : END_TC;
   end

   flow_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (resetN),
      .clr_i      (timer_clr),
      .load_i     (1'b0),
      .load_val_i ({CNT_W{1'b0}}),
      .en_i       (timer_en),
      .tc_val_i   (timer_tc_val),
      .count_o    (timer_count),
      .tc_o       (timer_tc)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_WELCOME;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
      end
   end

   always_comb begin
      start                    = (state_q != S_WELCOME);
      game_end                 = (state_q == S_GAME_OVER) || (state_q == S_WIN);
      freeze                   = (state_q == S_PAUSE) || (state_q == S_LEVEL_UP) ||
                                 (state_q == S_GAME_OVER) || (state_q == S_WIN);
      paused                   = (state_q == S_PAUSE);
      levelBannerOn            = (state_q == S_LEVEL_UP);
      gameWon                  = (state_q == S_WIN);
      screenWelcomeOperational = (state_q == S_WELCOME);
      level                    = level_q;
   end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - directed self-checking bench for game_flow_controller
module tb_game_flow_controller;

   localparam int LIFE_W        = 4;
   localparam int NUM_LEVELS    = 4;
   localparam int LEVEL_W       = 3;
   localparam int BANNER_CYCLES = 5;
   localparam int END_TIMEOUT   = 8;

   // {start, game_end, freeze, paused, levelBannerOn, gameWon, screenWelcomeOperational}
   localparam logic [6:0] F_WELCOME   = 7'b0000001;
   localparam logic [6:0] F_PLAY      = 7'b1000000;
   localparam logic [6:0] F_PAUSE     = 7'b1011000;
   localparam logic [6:0] F_LEVEL_UP  = 7'b1010100;
   localparam logic [6:0] F_GAME_OVER = 7'b1110000;
   localparam logic [6:0] F_WIN       = 7'b1110010;

   logic clk = 1'b0;
   logic resetN;
   logic keyStartPressed, keyPausePressed, keyRestartPressed, levelCleared;
   logic [LIFE_W-1:0]  life;
   logic start, game_end, freeze, paused, levelBannerOn, gameWon, screenWelcomeOperational;
   logic [LEVEL_W-1:0] level;
   logic [6:0] flags;

   int tests = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign flags = {start, game_end, freeze, paused, levelBannerOn, gameWon, screenWelcomeOperational};

   game_flow_controller #(
      .LIFE_W        (LIFE_W),
      .NUM_LEVELS    (NUM_LEVELS),
      .LEVEL_W       (LEVEL_W),
      .BANNER_CYCLES (BANNER_CYCLES),
      .END_TIMEOUT   (END_TIMEOUT)
   ) dut (
      .clk                      (clk),
      .resetN                   (resetN),
      .keyStartPressed          (keyStartPressed),
      .keyPausePressed          (keyPausePressed),
      .keyRestartPressed        (keyRestartPressed),
      .life                     (life),
      .levelCleared             (levelCleared),
      .start                    (start),
      .game_end                 (game_end),
      .freeze                   (freeze),
      .paused                   (paused),
      .levelBannerOn            (levelBannerOn),
      .gameWon                  (gameWon),
      .screenWelcomeOperational (screenWelcomeOperational),
      .level                    (level)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press_start();
      keyStartPressed = 1'b1; tick(); keyStartPressed = 1'b0;
   endtask

   task automatic press_pause();
      keyPausePressed = 1'b1; tick(); keyPausePressed = 1'b0;
   endtask

   task automatic press_restart();
      keyRestartPressed = 1'b1; tick(); keyRestartPressed = 1'b0;
   endtask

   task automatic clear_level();
      levelCleared = 1'b1; tick(); levelCleared = 1'b0;
   endtask

   // Called right after the edge that entered S_LEVEL_UP; banner must last BANNER_CYCLES samples.
   task automatic banner(input logic [LEVEL_W-1:0] lvl, input bit poke_keys);
      check("banner_entry", flags, F_LEVEL_UP);
      check("banner_level", level, lvl);
      for (int i = 1; i < BANNER_CYCLES; i++) begin
         if (poke_keys && i == 2) begin
            keyPausePressed = 1'b1;
            keyRestartPressed = 1'b1;
            levelCleared = 1'b1;
         end
         tick();
         keyPausePressed = 1'b0;
         keyRestartPressed = 1'b0;
         levelCleared = 1'b0;
         check("banner_hold", flags, F_LEVEL_UP);
      end
      tick();
      check("banner_exit", flags, F_PLAY);
      check("banner_exit_level", level, lvl);
   endtask

   initial begin
      resetN = 1'b0;
      keyStartPressed = 1'b0;
      keyPausePressed = 1'b0;
      keyRestartPressed = 1'b0;
      levelCleared = 1'b0;
      life = 4'd3;
      tick();
      tick();
      check("reset_flags", flags, F_WELCOME);
      check("reset_level", level, 0);
      resetN = 1'b1;

      // Welcome ignores everything except start.
      clear_level();
      press_pause();
      life = 4'd0;
      tick();
      life = 4'd3;
      check("welcome_ignores", flags, F_WELCOME);

      press_start();
      check("start_flags", flags, F_PLAY);
      check("start_level", level, 0);

      clear_level();
      banner(3'd1, 1'b1);
      clear_level();
      banner(3'd2, 1'b0);
      clear_level();
      banner(3'd3, 1'b0);
      clear_level();
      check("win_flags", flags, F_WIN);
      check("win_level", level, 3);
      tick();
      check("win_hold", flags, F_WIN);
      press_restart();
      check("win_restart", flags, F_WELCOME);
      check("welcome_level_held", level, 3);

      // Pause masks life==0 until play resumes.
      press_start();
      check("restart_level", level, 0);
      press_pause();
      check("pause_flags", flags, F_PAUSE);
      life = 4'd0;
      tick();
      tick();
      check("pause_ignores_life", flags, F_PAUSE);
      press_pause();
      check("resume_play", flags, F_PLAY);
      tick();
      check("game_over", flags, F_GAME_OVER);
      press_restart();
      check("game_over_restart", flags, F_WELCOME);
      life = 4'd3;

      // Simultaneous life==0 and levelCleared: game over wins; then end timeout.
      press_start();
      clear_level();
      banner(3'd1, 1'b0);
      life = 4'd0;
      levelCleared = 1'b1;
      tick();
      levelCleared = 1'b0;
      life = 4'd3;
      check("tie_flags", flags, F_GAME_OVER);
      check("tie_level", level, 1);
      for (int i = 1; i < END_TIMEOUT; i++) begin
         tick();
         check("go_hold", flags, F_GAME_OVER);
      end
      tick();
      check("go_timeout", flags, F_WELCOME);
      check("go_timeout_level", level, 1);

      // Asynchronous reset in the middle of the banner.
      press_start();
      clear_level();
      tick();
      tick();
      check("pre_reset_banner", flags, F_LEVEL_UP);
      #2;
      resetN = 1'b0;
      #1;
      check("async_reset_flags", flags, F_WELCOME);
      check("async_reset_level", level, 0);
      check("async_reset_count", dut.timer_count, 0);
      tick();
      resetN = 1'b1;

      // Banner timing after reset proves the counter restarted from zero.
      press_start();
      clear_level();
      banner(3'd1, 1'b0);
      press_pause();
      press_restart();
      check("pause_restart", flags, F_WELCOME);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
